// File: rtl/rr_issue_arbiter.sv
// Round-robin issue arbiter: rotating base pointer, wrap-around first-set search,
// one registered grant per cycle over a valid/ready handshake.
module rr_issue_arbiter #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             flush,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] base_ptr
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
    logic [IDX_W-1:0] base_ptr_q, base_ptr_d;

    logic [N-1:0]     srch_vec;
    logic [IDX_W-1:0] srch_base;
    logic [IDX_W-1:0] next_base;
    logic             srch_found;
    logic [IDX_W-1:0] srch_win;
    logic             accept;

    // First set bit of vec scanning b, b+1, ... with wrap; MSB of result is "found".
    function automatic logic [IDX_W:0] sel(input logic [N-1:0] vec, input logic [IDX_W-1:0] b);
        logic             found;
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = b + IDX_W'(k);
            if (!found && vec[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // In HOLD the search looks past the current winner so an accept can chain a new grant.
    always_comb begin
        next_base = gnt_idx_q + IDX_W'(1);
        accept    = (state_q == HOLD) && gnt_ready;
        if (state_q == HOLD) begin
            srch_vec  = req & ~gnt_onehot_q;
            srch_base = next_base;
        end else begin
            srch_vec  = req;
            srch_base = base_ptr_q;
        end
        {srch_found, srch_win} = sel(srch_vec, srch_base);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (srch_found) state_d = HOLD;
                HOLD:    if (gnt_ready)  state_d = srch_found ? HOLD : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Flush dominates accept: nothing advances and nothing new is loaded.
    always_comb begin
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        base_ptr_d   = base_ptr_q;
        if (flush) begin
            gnt_valid_d  = 1'b0;
            gnt_onehot_d = '0;
        end else if (state_q == IDLE) begin
            if (srch_found) begin
                gnt_valid_d  = 1'b1;
                gnt_idx_d    = srch_win;
                gnt_onehot_d = N'(1) << srch_win;
            end
        end else if (accept) begin
            base_ptr_d = next_base;
            if (srch_found) begin
                gnt_valid_d  = 1'b1;
                gnt_idx_d    = srch_win;
                gnt_onehot_d = N'(1) << srch_win;
            end else begin
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            base_ptr_q   <= '0;
        end else begin
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            base_ptr_q   <= base_ptr_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign base_ptr   = base_ptr_q;

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Directed, table-driven bench for rr_issue_arbiter with hand-computed expectations.
module tb_rr_issue_arbiter;

    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 4;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic             flush;
    logic             gnt_ready;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;
    logic [IDX_W-1:0] base_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             rst_before;
        logic [N-1:0]     req;
        logic             flush;
        logic             ready;
        logic             exp_valid;
        logic [IDX_W-1:0] exp_idx;
        logic [IDX_W-1:0] exp_base;
    } vec_t;

    vec_t vecs[$];

    rr_issue_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flush      (flush),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .base_ptr   (base_ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [IDX_W-1:0] ei,
                             input logic [IDX_W-1:0] eb);
        logic [N-1:0] exp_oh;
        exp_oh = ev ? (N'(1) << ei) : '0;
        cmp({tag, " gnt_valid"}, 32'(gnt_valid), 32'(ev));
        if (ev) cmp({tag, " gnt_idx"}, 32'(gnt_idx), 32'(ei));
        cmp({tag, " gnt_onehot"}, 32'(gnt_onehot), 32'(exp_oh));
        cmp({tag, " base_ptr"}, 32'(base_ptr), 32'(eb));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        flush     = 1'b0;
        gnt_ready = 1'b0;
        @(posedge clk);
        #1;
        check_out("reset", 1'b0, '0, '0);
        cmp("reset gnt_idx", 32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add(input logic rb, input logic [N-1:0] r, input logic f, input logic rdy,
                       input logic ev, input int ei, input int eb);
        vec_t v;
        v.rst_before = rb;
        v.req        = r;
        v.flush      = f;
        v.ready      = rdy;
        v.exp_valid  = ev;
        v.exp_idx    = IDX_W'(ei);
        v.exp_base   = IDX_W'(eb);
        vecs.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        flush     = 1'b0;
        gnt_ready = 1'b0;

        // T1: two requesters at the extremes alternate, base_ptr wraps 15 -> 0
        add(1, 16'h8001, 0, 1, 1, 0, 0);
        add(0, 16'h8001, 0, 1, 1, 15, 1);
        add(0, 16'h8001, 0, 1, 1, 0, 0);
        add(0, 16'h8001, 0, 1, 1, 15, 1);
        add(0, 16'h8001, 0, 1, 1, 0, 0);
        // T2: all requesting, back-to-back grants with no bubble
        add(1, 16'hFFFF, 0, 1, 1, 0, 0);
        for (int k = 2; k <= 17; k++) add(0, 16'hFFFF, 0, 1, 1, (k - 1) % 16, (k - 1) % 16);
        // T3: grant held through stall and req changes, then accept
        add(1, 16'h0008, 0, 0, 1, 3, 0);
        add(0, 16'h0000, 0, 0, 1, 3, 0);
        add(0, 16'hFFF7, 0, 0, 1, 3, 0);
        add(0, 16'h0010, 0, 0, 1, 3, 0);
        add(0, 16'h0001, 0, 0, 1, 3, 0);
        add(0, 16'h0000, 0, 0, 1, 3, 0);
        add(0, 16'h0000, 0, 1, 0, 0, 4);
        add(0, 16'h0000, 0, 1, 0, 0, 4);
        add(0, 16'h0004, 0, 0, 1, 2, 4);
        // T4: search from base 14 wraps to bit 2, then bit 13
        add(1, 16'h2000, 0, 1, 1, 13, 0);
        add(0, 16'h2000, 0, 1, 0, 0, 14);
        add(0, 16'h2004, 0, 0, 1, 2, 14);
        add(0, 16'h2004, 0, 1, 1, 13, 3);
        add(0, 16'h0000, 0, 1, 0, 0, 14);
        // T5: flush beats a same-cycle accept; re-grant once flush drops
        add(1, 16'h0020, 0, 0, 1, 5, 0);
        add(0, 16'h0020, 1, 1, 0, 0, 0);
        add(0, 16'h0020, 1, 0, 0, 0, 0);
        add(0, 16'h0020, 0, 0, 1, 5, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            req       = vecs[i].req;
            flush     = vecs[i].flush;
            gnt_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_base);
        end

        // T6: asynchronous reset mid-HOLD, then first grant searched from base 0
        do_reset();
        req       = 16'h0100;
        gnt_ready = 1'b0;
        @(posedge clk);
        #1;
        check_out("t6 pre8", 1'b1, 4'd8, 4'd0);
        req       = 16'h0200;
        gnt_ready = 1'b1;
        @(posedge clk);
        #1;
        check_out("t6 hold9", 1'b1, 4'd9, 4'd9);
        gnt_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_out("t6 async", 1'b0, '0, '0);
        cmp("t6 async gnt_idx", 32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 16'h0200;
        @(posedge clk);
        #1;
        check_out("t6 regrant", 1'b1, 4'd9, 4'd0);
        req       = '0;
        gnt_ready = 1'b1;
        @(posedge clk);
        #1;
        check_out("t6 accept", 1'b0, '0, 4'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
